// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS datapath widths plus write-back selector and load-type encodings
package mips_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;
  localparam logic [2:0] LD_W = 3'd0;
  localparam logic [2:0] LD_B = 3'd1;
  localparam logic [2:0] LD_BU = 3'd2;
  localparam logic [2:0] LD_H = 3'd3;
  localparam logic [2:0] LD_HU = 3'd4;
endpackage

// File: rtl/load_align.sv
// load_align: big-endian byte/half extraction with sign/zero extension; in mem_rdata_i, offset_i, load_type_i; out data_o, misalign_o
module load_align
  import mips_pkg::*;
(
  input  logic [31:0] mem_rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  load_type_i,
  output logic [31:0] data_o,
  output logic        misalign_o
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  always_comb begin
    byte_v = offset_i == 2'd0 ? mem_rdata_i[31:24] :
             offset_i == 2'd1 ? mem_rdata_i[23:16] :
             offset_i == 2'd2 ? mem_rdata_i[15:8] : mem_rdata_i[7:0];
    half_v = offset_i[1] ? mem_rdata_i[15:0] : mem_rdata_i[31:16];
    data_o = load_type_i == LD_B  ? {{24{byte_v[7]}}, byte_v} :
             load_type_i == LD_BU ? {24'b0, byte_v} :
             load_type_i == LD_H  ? {{16{half_v[15]}}, half_v} :
             load_type_i == LD_HU ? {16'b0, half_v} : mem_rdata_i;
    misalign_o = (load_type_i == LD_H || load_type_i == LD_HU) ? offset_i[0] :
                 (load_type_i == LD_B || load_type_i == LD_BU) ? 1'b0 : |offset_i;
  end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB register + write-back formatter driving RegWrite/WriteReg/WriteData, WbValid, AddrErr, RetireCnt; MEM_WB_BYPASS_EN adds ReadReg/ReadData in, FwdData out
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              InValid,
  input  logic              RegWriteIn,
  input  logic [REG_AW-1:0] WriteRegIn,
  input  logic [1:0]        WbSel,
  input  logic [2:0]        LoadType,
  input  logic [DATA_W-1:0] AluResult,
  input  logic [DATA_W-1:0] MemReadData,
  input  logic [DATA_W-1:0] LinkAddr,
  output logic              RegWrite,
  output logic [REG_AW-1:0] WriteReg,
  output logic [DATA_W-1:0] WriteData,
  output logic              WbValid,
  output logic              AddrErr,
  output logic [31:0]       RetireCnt
`ifdef MEM_WB_BYPASS_EN
  ,
  input  logic [REG_AW-1:0] ReadReg1,
  input  logic [REG_AW-1:0] ReadReg2,
  input  logic [DATA_W-1:0] ReadData1,
  input  logic [DATA_W-1:0] ReadData2,
  output logic [DATA_W-1:0] FwdData1,
  output logic [DATA_W-1:0] FwdData2
`endif
);
  logic [DATA_W-1:0] ld_data;
  logic              ld_mis, mis;
  logic              rw_d, rw_q, valid_d, valid_q, aerr_d, aerr_q;
  logic [REG_AW-1:0] wreg_d, wreg_q;
  logic [DATA_W-1:0] wdata_d, wdata_q;
  logic [31:0]       cnt_d, cnt_q;
  load_align u_align (
    .mem_rdata_i(MemReadData),
    .offset_i   (AluResult[1:0]),
    .load_type_i(LoadType),
    .data_o     (ld_data),
    .misalign_o (ld_mis)
  );
  always_comb begin
    mis     = (WbSel == WB_MEM) & ld_mis;
    valid_d = InValid;
    aerr_d  = InValid & mis;
    rw_d    = InValid & RegWriteIn & (WriteRegIn != '0) & ~mis;
    wreg_d  = WriteRegIn;
    wdata_d = WbSel == WB_MEM ? ld_data : WbSel == WB_LINK ? LinkAddr : AluResult;
    cnt_d   = cnt_q + {31'b0, rw_d};
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rw_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
      valid_q <= 1'b0;
      aerr_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (Flush) begin
      rw_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
      valid_q <= 1'b0;
      aerr_q  <= 1'b0;
    end else if (!Stall) begin
      rw_q    <= rw_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
      aerr_q  <= aerr_d;
      cnt_q   <= cnt_d;
    end
  end
  assign RegWrite  = rw_q;
  assign WriteReg  = wreg_q;
  assign WriteData = wdata_q;
  assign WbValid   = valid_q;
  assign AddrErr   = aerr_q;
  assign RetireCnt = cnt_q;
`ifdef MEM_WB_BYPASS_EN
  assign FwdData1 = (rw_q && wreg_q == ReadReg1 && ReadReg1 != '0) ? wdata_q : ReadData1;
  assign FwdData2 = (rw_q && wreg_q == ReadReg2 && ReadReg2 != '0) ? wdata_q : ReadData2;
`endif
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: table-driven scoreboard bench for mem_wb_stage
module tb_mem_wb_stage;
  import mips_pkg::*;
  logic        clk = 1'b0;
  logic        rst, stall, flush, inv, rwin;
  logic [4:0]  wreg_in;
  logic [1:0]  sel;
  logic [2:0]  lt;
  logic [31:0] alu, mrd, link;
  logic        RegWrite, WbValid, AddrErr;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData, RetireCnt;
`ifdef MEM_WB_BYPASS_EN
  logic [4:0]  rr1 = '0, rr2 = '0;
  logic [31:0] rd1 = '0, rd2 = '0, fwd1, fwd2;
`endif
  int ncmp = 0;
  int nfail = 0;
  typedef struct {
    logic        rw;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic        valid;
    logic        aerr;
    logic [31:0] cnt;
  } exp_t;
  typedef struct {
    logic        inv;
    logic        rwin;
    logic [4:0]  wreg;
    logic [1:0]  sel;
    logic [2:0]  lt;
    logic [31:0] alu;
    logic [31:0] mrd;
    logic [31:0] link;
    logic        erw;
    logic [31:0] ewd;
    logic        eaerr;
  } vec_t;
  exp_t sbq[$];
  vec_t vt[$];
  exp_t last;
  logic [31:0] ecnt = '0;
  always #5 clk = ~clk;
  mem_wb_stage dut (
    .Clk(clk), .Rst(rst), .Stall(stall), .Flush(flush), .InValid(inv),
    .RegWriteIn(rwin), .WriteRegIn(wreg_in), .WbSel(sel), .LoadType(lt),
    .AluResult(alu), .MemReadData(mrd), .LinkAddr(link),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .WbValid(WbValid), .AddrErr(AddrErr), .RetireCnt(RetireCnt)
`ifdef MEM_WB_BYPASS_EN
    , .ReadReg1(rr1), .ReadReg2(rr2), .ReadData1(rd1), .ReadData2(rd2),
    .FwdData1(fwd1), .FwdData2(fwd2)
`endif
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    ncmp++;
    if (a !== x) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", n, a, x);
    end
  endtask
  function automatic vec_t v(input logic i, input logic r, input logic [4:0] w, input logic [1:0] s,
                             input logic [2:0] l, input logic [31:0] a, input logic [31:0] m,
                             input logic [31:0] k, input logic erw, input logic [31:0] ewd, input logic ea);
    vec_t t;
    t.inv = i; t.rwin = r; t.wreg = w; t.sel = s; t.lt = l; t.alu = a; t.mrd = m; t.link = k;
    t.erw = erw; t.ewd = ewd; t.eaerr = ea;
    return t;
  endfunction
  task automatic drive(input vec_t t);
    inv = t.inv; rwin = t.rwin; wreg_in = t.wreg; sel = t.sel; lt = t.lt;
    alu = t.alu; mrd = t.mrd; link = t.link;
  endtask
  task automatic push(input logic rw, input logic [4:0] w, input logic [31:0] d, input logic vl,
                      input logic ae, input logic [31:0] c);
    exp_t e;
    e.rw = rw; e.wreg = w; e.wdata = d; e.valid = vl; e.aerr = ae; e.cnt = c;
    sbq.push_back(e);
    last = e;
  endtask
  task automatic tick_check(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      ncmp++;
      nfail++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sbq.pop_front();
      chk({tag, ".RegWrite"}, {31'b0, RegWrite}, {31'b0, e.rw});
      chk({tag, ".WriteReg"}, {27'b0, WriteReg}, {27'b0, e.wreg});
      chk({tag, ".WriteData"}, WriteData, e.wdata);
      chk({tag, ".WbValid"}, {31'b0, WbValid}, {31'b0, e.valid});
      chk({tag, ".AddrErr"}, {31'b0, AddrErr}, {31'b0, e.aerr});
      chk({tag, ".RetireCnt"}, RetireCnt, e.cnt);
    end
  endtask
  task automatic run_vec(input vec_t t, input string tag);
    drive(t);
    if (t.erw) ecnt++;
    push(t.erw, t.wreg, t.ewd, t.inv, t.eaerr, ecnt);
    tick_check(tag);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    vt.push_back(v(1, 1, 8, WB_ALU, LD_W, 32'h12345678, 32'h0, 32'h0, 1, 32'h12345678, 0));
    vt.push_back(v(1, 1, 9, WB_MEM, LD_B, 32'h1001, 32'h80FF7F01, 32'h0, 1, 32'hFFFFFFFF, 0));
    vt.push_back(v(1, 1, 9, WB_MEM, LD_BU, 32'h1001, 32'h80FF7F01, 32'h0, 1, 32'h000000FF, 0));
    vt.push_back(v(1, 1, 9, WB_MEM, LD_H, 32'h1002, 32'h80FF7F01, 32'h0, 1, 32'h00007F01, 0));
    vt.push_back(v(1, 1, 9, WB_MEM, LD_H, 32'h1003, 32'h80FF7F01, 32'h0, 0, 32'h00007F01, 1));
    vt.push_back(v(1, 1, 0, WB_ALU, LD_W, 32'h5, 32'h0, 32'h0, 0, 32'h5, 0));
    vt.push_back(v(1, 1, 10, WB_MEM, LD_HU, 32'h1000, 32'h80FF7F01, 32'h0, 1, 32'h000080FF, 0));
    vt.push_back(v(1, 1, 10, WB_MEM, LD_H, 32'h1000, 32'h80FF7F01, 32'h0, 1, 32'hFFFF80FF, 0));
    vt.push_back(v(1, 1, 11, WB_MEM, LD_B, 32'h1000, 32'h80FF7F01, 32'h0, 1, 32'hFFFFFF80, 0));
    vt.push_back(v(1, 1, 11, WB_MEM, LD_B, 32'h1003, 32'h80FF7F01, 32'h0, 1, 32'h00000001, 0));
    vt.push_back(v(1, 1, 12, WB_MEM, LD_W, 32'h1000, 32'h80FF7F01, 32'h0, 1, 32'h80FF7F01, 0));
    vt.push_back(v(1, 1, 12, WB_MEM, LD_W, 32'h1002, 32'h80FF7F01, 32'h0, 0, 32'h80FF7F01, 1));
    vt.push_back(v(1, 1, 31, WB_LINK, LD_W, 32'h1, 32'h0, 32'h00400008, 1, 32'h00400008, 0));
    vt.push_back(v(1, 1, 13, 2'd3, LD_W, 32'hDEAD0000, 32'h1, 32'h2, 1, 32'hDEAD0000, 0));
    vt.push_back(v(0, 1, 4, WB_MEM, LD_W, 32'h1001, 32'h80FF7F01, 32'h0, 0, 32'h80FF7F01, 0));
    vt.push_back(v(1, 0, 7, WB_ALU, LD_W, 32'h77, 32'h0, 32'h0, 0, 32'h77, 0));
    vt.push_back(v(1, 1, 14, WB_MEM, 3'd7, 32'h1000, 32'hCAFEBABE, 32'h0, 1, 32'hCAFEBABE, 0));
    rst = 1; stall = 0; flush = 0;
    drive(v(1, 1, 3, WB_ALU, LD_W, 32'hFFFF, 32'h0, 32'h0, 0, 32'h0, 0));
    repeat (2) @(posedge clk);
    #1;
    push(0, 0, 0, 0, 0, 0);
    sbq.pop_front();
    chk("rst.RegWrite", {31'b0, RegWrite}, 32'h0);
    chk("rst.WriteReg", {27'b0, WriteReg}, 32'h0);
    chk("rst.WriteData", WriteData, 32'h0);
    chk("rst.WbValid", {31'b0, WbValid}, 32'h0);
    chk("rst.AddrErr", {31'b0, AddrErr}, 32'h0);
    chk("rst.RetireCnt", RetireCnt, 32'h0);
    rst = 0;
    foreach (vt[i]) run_vec(vt[i], $sformatf("vec%0d", i));
    run_vec(v(1, 1, 20, WB_ALU, LD_W, 32'hAAAA0001, 32'h0, 32'h0, 1, 32'hAAAA0001, 0), "pre_stall");
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      drive(v(1, 1, 5'(21 + k), WB_ALU, LD_W, $urandom, 32'h0, 32'h0, 0, 32'h0, 0));
      push(last.rw, last.wreg, last.wdata, last.valid, last.aerr, last.cnt);
      tick_check($sformatf("stall%0d", k));
    end
    flush = 1;
    drive(v(1, 1, 22, WB_ALU, LD_W, 32'h1234, 32'h0, 32'h0, 0, 32'h0, 0));
    push(0, 0, 0, 0, 0, ecnt);
    tick_check("flush_stall");
    flush = 0; stall = 0;
    run_vec(v(1, 1, 23, WB_ALU, LD_W, 32'h55, 32'h0, 32'h0, 1, 32'h55, 0), "post_flush");
    stall = 1; rst = 1;
    push(0, 0, 0, 0, 0, 0);
    tick_check("rst_in_stall");
    rst = 0; stall = 0; ecnt = '0;
    run_vec(v(1, 1, 5, WB_ALU, LD_W, 32'h7, 32'h0, 32'h0, 1, 32'h7, 0), "post_rst");
`ifdef MEM_WB_BYPASS_EN
    rr1 = 5; rd1 = 32'h3; rr2 = 0; rd2 = 32'h55;
    #1;
    chk("fwd1_hit", fwd1, 32'h7);
    chk("fwd2_zero", fwd2, 32'h55);
    rr1 = 6;
    #1;
    chk("fwd1_miss", fwd1, 32'h3);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
MEM/WB pipeline register and write-back formatter for the MIPS datapath. It sits directly upstream of the register file and drives its RegWrite, WriteReg and WriteData inputs.
- Captures the ALU result, load data and link address from the MEM stage.
- Performs load byte/halfword extraction and sign/zero extension.
- Selects the write-back source and suppresses illegal writes.
- Keeps a retired-write counter for debug.

Parameters:
DATA_W, 32, datapath width; must be 32 for the load-extraction logic.
REG_AW, 5, register address width.

Ports:
Clk  in  1  rising-edge clock.
Rst  in  1  synchronous, active-high reset.
Stall  in  1  hold the current WB contents.
Flush  in  1  replace the incoming instruction with a bubble.
InValid  in  1  MEM stage holds a real instruction.
RegWriteIn  in  1  the instruction writes a register.
WriteRegIn  in  REG_AW  destination register number.
WbSel  in  2  write-back source: 0 = ALU, 1 = MEM, 2 = PC+8 (link), 3 = reserved, treated as 0.
LoadType  in  3  0 = lw, 1 = lb, 2 = lbu, 3 = lh, 4 = lhu, others = lw.
AluResult  in  DATA_W  ALU output; also the memory byte address.
MemReadData  in  DATA_W  aligned word read from data memory.
LinkAddr  in  DATA_W  PC+8 for jal/jalr.
RegWrite  out  1  to the register file.
WriteReg  out  REG_AW  to the register file.
WriteData  out  DATA_W  signed, to the register file.
WbValid  out  1  WB stage holds a real instruction.
AddrErr  out  1  the captured load was misaligned.
RetireCnt  out  32  count of committed register writes.

Behaviour:
- All outputs are registered and update on posedge Clk. Latency is 1 cycle from MEM inputs to register-file inputs.
- Priority per edge: Rst > Flush > Stall > normal capture.
- Rst: RegWrite=0, WriteReg=0, WriteData=0, WbValid=0, AddrErr=0, RetireCnt=0. Reset mid-stall also clears everything.
- Flush: RegWrite=0, WbValid=0, AddrErr=0. WriteReg and WriteData are zeroed. RetireCnt is held. Flush overrides Stall.
- Stall (without Flush): every register holds, including RetireCnt.
- Capture: WbValid <= InValid.
- Capture, RegWrite: RegWrite <= InValid & RegWriteIn & (WriteRegIn != 0) & ~misaligned. Writes to $zero never assert RegWrite.
- Capture, WriteReg and WriteData: WriteReg <= WriteRegIn; WriteData <= selected source.
- Load extraction is big-endian; byte offset b = AluResult[1:0].
  - Byte lane: MemReadData[31-8b -: 8].
  - Halfword lane: b=0 gives [31:16]; b=2 gives [15:0].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
- Misalignment:
  - lh/lhu is misaligned when AluResult[0]=1.
  - lw is misaligned when AluResult[1:0]!=0.
  - AddrErr <= InValid & (WbSel==1) & misaligned.
  - Misaligned loads suppress RegWrite; WriteData is still the computed value.
- RetireCnt increments by 1 on each capture edge where the new RegWrite is 1. It wraps 0xFFFFFFFF -> 0.
- The output register is a single slot with no buffering. Back-pressure comes only from Stall.

Optional Feature:
MEM_WB_BYPASS_EN
- Defined: adds inputs ReadReg1 and ReadReg2 (REG_AW each) and ReadData1 and ReadData2 (DATA_W each). Adds outputs FwdData1 and FwdData2 (DATA_W each).
- Defined, forwarding rule: FwdDataN = (RegWrite && WriteReg == ReadRegN && ReadRegN != 0) ? WriteData : ReadDataN. This path is combinational and provides write-through so a same-cycle read after write returns the new value.
- Not defined: these ports are absent. Decode reads the register file directly, and software or the hazard unit must insert a cycle between a write and a dependent read.

Decomposition:
- Package mips_pkg holds:
  - WB_ALU, WB_MEM and WB_LINK selector constants.
  - LD_W, LD_B, LD_BU, LD_H and LD_HU load-type constants.
  - DATA_W and REG_AW defaults.
- One sub-module, load_align: purely combinational. Inputs are MemReadData, the offset and LoadType; outputs are the extended data and the misalign flag. It is reusable by a future cache-bypass path.
- Pipeline registers, selection and the counter stay in mem_wb_stage.

Test Plan:
- Rst=1 for 2 cycles, then 0 -> all outputs 0, RetireCnt=0.
- InValid=1, RegWriteIn=1, WriteRegIn=8, WbSel=0, AluResult=0x12345678 -> next cycle RegWrite=1, WriteReg=8, WriteData=0x12345678, RetireCnt=1.
- WbSel=1, MemReadData=0x80FF7F01, AluResult=...1, LoadType=lb -> WriteData=0xFFFFFFFF.
- Same stimulus with LoadType=lbu -> WriteData=0x000000FF.
- Same stimulus with LoadType=lh and AluResult=...2 -> WriteData=0x00007F01.
- lh at AluResult=...3 -> AddrErr=1, RegWrite=0, RetireCnt unchanged.
- WriteRegIn=0, RegWriteIn=1 -> RegWrite=0, RetireCnt unchanged.
- Stall=1 for 3 cycles with changing inputs -> outputs frozen.
- Assert Flush with Stall -> bubble, WbValid=0.
- MEM_WB_BYPASS_EN defined: RegWrite=1, WriteReg=5, WriteData=7, ReadReg1=5, ReadData1=3 -> FwdData1=7.
- Same bypass setup with ReadReg2=0 -> FwdData2=ReadData2.
